// File: rtl/bsg_serial_in_packet_lock_arbiter_pkg.sv
// Shared types and helpers for the packet-lock arbiter in front of a serial-in assembler.
package bsg_serial_in_packet_lock_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  // Width of an index into x entries, never narrower than one bit.
  function automatic int unsigned safe_clog2(int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_rr_rotate_priority_select.sv
// Combinational rotating-priority select: searches req_i from last_i+1 upward with wrap.
module bsg_rr_rotate_priority_select #(
  parameter int unsigned num_in_p     = 2,
  parameter int unsigned lg_num_in_lp = 1
) (
  input  logic [num_in_p-1:0]     req_i,
  input  logic [lg_num_in_lp-1:0] last_i,
  output logic [num_in_p-1:0]     grant_o,
  output logic [lg_num_in_lp-1:0] idx_o,
  output logic                    v_o
);

  always_comb begin
    int unsigned cand;
    logic [lg_num_in_lp-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    grant_o  = '0;
    idx_o    = '0;
    v_o      = 1'b0;
    // The previous winner is visited last, giving it the lowest priority.
    for (int unsigned i = 1; i <= num_in_p; i++) begin
      cand     = (32'(last_i) + i) % num_in_p;
      cand_idx = lg_num_in_lp'(cand);
      if (!v_o && req_i[cand_idx]) begin
        v_o               = 1'b1;
        idx_o             = cand_idx;
        grant_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_serial_in_packet_lock_arbiter.sv
// Round-robin arbiter that locks onto one requester for a full els_p-word bundle so words
// from different requesters never interleave inside an assembled bundle.
module bsg_serial_in_packet_lock_arbiter
  import bsg_serial_in_packet_lock_arbiter_pkg::*;
#(
  parameter int unsigned  width_p      = 8,
  parameter int unsigned  els_p        = 4,
  parameter int unsigned  num_in_p     = 3,
  localparam int unsigned lg_num_in_lp = safe_clog2(num_in_p),
  localparam int unsigned lg_els_lp    = safe_clog2(els_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         ready_and_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic [lg_num_in_lp-1:0]     chan_o,
  output logic                        last_o,
  input  logic                        ready_and_i
);

  state_e                  state_q, state_d;
  logic [lg_num_in_lp-1:0] grant_q, grant_d;
  logic [lg_num_in_lp-1:0] last_q, last_d;
  logic [lg_els_lp-1:0]    cnt_q, cnt_d;

  logic [num_in_p-1:0]     rr_grant, grant_oh;
  logic [lg_num_in_lp-1:0] rr_idx, sel;
  logic                    rr_v, locked, cnt_last, accept;

  bsg_rr_rotate_priority_select #(
    .num_in_p    (num_in_p),
    .lg_num_in_lp(lg_num_in_lp)
  ) rr_select (
    .req_i  (v_i),
    .last_i (last_q),
    .grant_o(rr_grant),
    .idx_o  (rr_idx),
    .v_o    (rr_v)
  );

  assign locked   = (state_q == StLocked);
  assign sel      = locked ? grant_q : rr_idx;
  assign cnt_last = (cnt_q == lg_els_lp'(els_p - 1));

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Zero-bubble: in IDLE the rotating winner is forwarded combinationally.
  assign v_o         = reset_n_i & (locked ? v_i[grant_q] : rr_v);
  assign data_o      = data_i[width_p*sel +: width_p];
  assign chan_o      = sel;
  assign last_o      = cnt_last;
  assign ready_and_o = (locked ? grant_oh : rr_grant) & {num_in_p{ready_and_i & reset_n_i}};
  assign accept      = v_o & ready_and_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (rr_v) begin
          if (accept && (els_p == 1)) begin
            last_d = rr_idx;
          end else begin
            // An unaccepted first word still takes the lock so data_o/chan_o stay stable.
            state_d = StLocked;
            grant_d = rr_idx;
            cnt_d   = accept ? lg_els_lp'(1) : '0;
          end
        end
      end
      StLocked: begin
        if (accept) begin
          if (cnt_last) begin
            state_d = StIdle;
            cnt_d   = '0;
            last_d  = grant_q;
          end else begin
            cnt_d = cnt_q + lg_els_lp'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
      last_q  <= lg_num_in_lp'(num_in_p - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/bsg_serial_in_packet_lock_arbiter.md
Name: bsg_serial_in_packet_lock_arbiter

Overview:
- Round-robin arbiter that shares one serial-in/parallel-out assembler (fixed ratio of els_p words per bundle) among num_in_p serial requesters.
- Once a requester presents its first word, the grant is locked to it for exactly els_p accepted words. Words from different requesters are therefore never interleaved inside one assembled bundle.
- Sits directly upstream of the assembler. Forwards the granted stream plus a channel tag and a last-word flag; the tag is valid on the beat that completes the bundle.

Parameters:
- width_p, no default (must be set), serial word width.
- els_p, no default (must be set), words per bundle; must be >= 1.
- num_in_p, no default (must be set), number of requesters; must be >= 1.
- lg_num_in_lp, localparam `BSG_SAFE_CLOG2(num_in_p)`, tag width.
- lg_els_lp, localparam `BSG_SAFE_CLOG2(els_p)`, beat counter width.

Ports:
- clk_i  in  1  clock; single clock domain.
- reset_n_i  in  1  reset; synchronous, active-low.
- v_i  in  num_in_p  per-requester valid.
- data_i  in  num_in_p x width_p  per-requester serial word.
- ready_and_o  out  num_in_p  per-requester ready; at most one bit high.
- v_o  out  1  valid toward the assembler.
- data_o  out  width_p  granted word.
- chan_o  out  lg_num_in_lp  index of the granted requester; valid whenever v_o is high.
- last_o  out  1  high when the current beat is word els_p-1 of the bundle.
- ready_and_i  in  1  assembler ready.

Behaviour:
- Interface decision: one clock, clk_i; reset_n_i is synchronous and active-low.
- State: state_r in {IDLE, LOCKED}, grant_r (lg_num_in_lp bits), cnt_r (lg_els_lp bits), last_r (previous winner).
- Reset (reset_n_i low at a clock edge): state_r=IDLE, cnt_r=0, grant_r=0, last_r=num_in_p-1, so requester 0 has highest priority first.
- While reset_n_i is low, v_o=0 and ready_and_o=0. Reset mid-bundle abandons the bundle; no partial-bundle flush is performed.
- Winner selection in IDLE: combinational rotating priority over v_i, searching from last_r+1 upward with wrap. sel = winner.
- Winner selection in LOCKED: sel = grant_r, and all other v_i are ignored.
- Outputs:
  - v_o = v_i[sel] (0 in IDLE if no v_i is set).
  - data_o = data_i[sel].
  - chan_o = sel.
  - ready_and_o[sel] = ready_and_i; all other ready bits are 0.
  - last_o = (cnt_r == els_p-1).
- Zero-bubble requirement: a word can be accepted in the same cycle it first appears in IDLE.
- IDLE with any v_i:
  - Accepted (v_o & ready_and_i) and els_p==1: stay IDLE; last_r <= sel.
  - Accepted and els_p>1: go LOCKED; grant_r <= sel; cnt_r <= 1.
  - Not accepted: go LOCKED; grant_r <= sel; cnt_r <= 0. The grant is now held, so data_o/chan_o stay stable while v_o is high.
- LOCKED, beat accepted:
  - If cnt_r == els_p-1: go IDLE; cnt_r <= 0; last_r <= grant_r.
  - Otherwise: cnt_r <= cnt_r+1.
- LOCKED, v_i[grant_r] low or not accepted: hold all state; no timeout. A stalled requester blocks the others by design.
- Simultaneous requests: exactly one winner. Losers see ready_and_o=0 and must hold their valid.
- Fairness: after a bundle completes, the completing requester has lowest priority. With N continuous requesters, each gets one bundle in every N bundles.
- Handshake rules: data_o and chan_o are stable while v_o=1 & ready_and_i=0. Ready-to-valid combinational paths from v_i and ready_and_i to outputs are permitted; no registered outputs.
- Latency: 0 cycles, in to out.

Decomposition:
- Package bsg_serial_in_packet_lock_arbiter_pkg: state enum typedef (e_idle, e_locked).
- Sub-module bsg_rr_rotate_priority_select: combinational; inputs a request vector and last_r; outputs a one-hot grant and a binary index. Reusable elsewhere.
- Beat counter and FSM stay in the top module.

Test Plan (width_p=8, els_p=4, num_in_p=3 unless noted):
- Single requester: reset, then v_i=3'b001 with words A0..A3 and ready_and_i=1 -> four accepted beats on consecutive cycles, chan_o=0, last_o high only on A3; state returns to IDLE.
- Contention: all three requesters valid from reset, ready held at 1 -> bundles granted in order ch0, ch1, ch2, ch0. Each bundle is 4 contiguous beats with no interleaving and no idle cycles.
- Backpressure on first beat: ready_and_i=0 for 3 cycles while ch1 and ch2 are valid -> chan_o stays 1 and data_o stays stable. Raising v_i[2] mid-stall does not change the grant; ready_and_o stays 3'b000.
- Stalled owner: ch0 locked after 2 beats, v_i[0] drops for 5 cycles while ch1 is valid -> v_o=0, ch1 ready=0; bundle resumes at cnt 2 when v_i[0] returns.
- Reset mid-bundle: reset_n_i low after beat 2 of ch1 -> v_o=0 during reset. After release, ch0 and ch1 both valid -> ch0 wins with cnt 0.
- els_p=1: two requesters continuously valid -> grants alternate every cycle, last_o=1 on every beat.
